// File: rtl/pipeline_controller.sv
// Five-stage pipeline sequencer: fill, run, load-use stall, branch flush and drain.
// Stage enables are Moore outputs decoded from the state register and a 2-bit phase counter.
module pipeline_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 stall_for_ldr,
    input  logic                 branch_taken,
    input  logic                 clear_stats,
    output logic                 fetch_en,
    output logic                 decode_en,
    output logic                 execute_en,
    output logic                 memory_en,
    output logic                 writeback_en,
    output logic                 execute_bubble,
    output logic                 pc_redirect,
    output logic                 busy,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] ldr_stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_RUN       = 3'd2,
        S_LDR_STALL = 3'd3,
        S_FLUSH     = 3'd4,
        S_DRAIN     = 3'd5,
        S_HALTED    = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic [CNT_WIDTH-1:0] ldr_cnt_q, ldr_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 ldr_inc, flush_inc;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        ldr_inc   = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FILL;
                    phase_d = 2'd0;
                end
            end
            S_FILL: begin
                // A branch can only resolve once the execute stage holds a real instruction.
                if (branch_taken && phase_q >= 2'd2) begin
                    state_d   = S_FLUSH;
                    phase_d   = 2'd0;
                    flush_inc = 1'b1;
                end else if (halt) begin
                    state_d = S_DRAIN;
                    phase_d = 2'd0;
                end else if (phase_q == 2'd3) begin
                    state_d = S_RUN;
                    phase_d = 2'd0;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            S_RUN, S_LDR_STALL: begin
                phase_d = 2'd0;
                if (branch_taken) begin
                    state_d   = S_FLUSH;
                    flush_inc = 1'b1;
                end else if (halt) begin
                    state_d = S_DRAIN;
                end else if (stall_for_ldr && state_q == S_RUN) begin
                    // The flag seen during the bubble belongs to the same hazard.
                    state_d = S_LDR_STALL;
                    ldr_inc = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (phase_q == 2'd0) begin
                    phase_d = 2'd1;
                end else begin
                    state_d = S_RUN;
                    phase_d = 2'd0;
                end
            end
            S_DRAIN: begin
                if (phase_q == 2'd3) begin
                    state_d = S_HALTED;
                    phase_d = 2'd0;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 2'd0;
            end
        endcase
    end

    // Saturating counters; a clear wins over a same-cycle increment.
    always_comb begin
        ldr_cnt_d   = ldr_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clear_stats) begin
            ldr_cnt_d   = '0;
            flush_cnt_d = '0;
        end else begin
            if (ldr_inc && ldr_cnt_q != '1)
                ldr_cnt_d = ldr_cnt_q + CNT_WIDTH'(1);
            if (flush_inc && flush_cnt_q != '1)
                flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= 2'd0;
            ldr_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            ldr_cnt_q   <= ldr_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        fetch_en       = 1'b0;
        decode_en      = 1'b0;
        execute_en     = 1'b0;
        memory_en      = 1'b0;
        writeback_en   = 1'b0;
        execute_bubble = 1'b0;
        pc_redirect    = 1'b0;
        busy           = 1'b1;
        case (state_q)
            S_IDLE, S_HALTED: busy = 1'b0;
            S_FILL: begin
                fetch_en   = 1'b1;
                decode_en  = (phase_q >= 2'd1);
                execute_en = (phase_q >= 2'd2);
                memory_en  = (phase_q == 2'd3);
            end
            S_RUN: begin
                fetch_en     = 1'b1;
                decode_en    = 1'b1;
                execute_en   = 1'b1;
                memory_en    = 1'b1;
                writeback_en = 1'b1;
            end
            S_LDR_STALL: begin
                execute_en     = 1'b1;
                memory_en      = 1'b1;
                writeback_en   = 1'b1;
                execute_bubble = 1'b1;
            end
            S_FLUSH: begin
                pc_redirect    = (phase_q == 2'd0);
                fetch_en       = (phase_q == 2'd1);
                execute_en     = 1'b1;
                memory_en      = 1'b1;
                writeback_en   = 1'b1;
                execute_bubble = 1'b1;
            end
            S_DRAIN: begin
                decode_en    = (phase_q < 2'd1);
                execute_en   = (phase_q < 2'd2);
                memory_en    = (phase_q < 2'd3);
                writeback_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign state           = state_q;
    assign ldr_stall_count = ldr_cnt_q;
    assign flush_count     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a per-cycle vector table plus hand sequences
// for counter saturation and asynchronous reset. 8-bit counters keep saturation short.
module tb_pipeline_controller;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0, halt = 1'b0, stall_for_ldr = 1'b0;
    logic          branch_taken = 1'b0, clear_stats = 1'b0;
    logic          fetch_en, decode_en, execute_en, memory_en, writeback_en;
    logic          execute_bubble, pc_redirect, busy;
    logic [2:0]    state;
    logic [CW-1:0] ldr_stall_count, flush_count;

    pipeline_controller #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .stall_for_ldr(stall_for_ldr), .branch_taken(branch_taken),
        .clear_stats(clear_stats), .fetch_en(fetch_en), .decode_en(decode_en),
        .execute_en(execute_en), .memory_en(memory_en), .writeback_en(writeback_en),
        .execute_bubble(execute_bubble), .pc_redirect(pc_redirect), .busy(busy),
        .state(state), .ldr_stall_count(ldr_stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // {state, fetch, decode, execute, memory, writeback, bubble, redirect, busy}
    logic [10:0] obs;
    assign obs = {state, fetch_en, decode_en, execute_en, memory_en, writeback_en,
                  execute_bubble, pc_redirect, busy};

    typedef struct {
        logic [4:0]    in;   // start, halt, stall, branch, clear
        logic [2:0]    st;
        logic [4:0]    en;   // fetch, decode, execute, memory, writeback
        logic          bub;
        logic          rdr;
        logic          bsy;
        logic [CW-1:0] ldr;
        logic [CW-1:0] fl;
    } vec_t;

    vec_t tab[26];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [4:0] in, input logic [2:0] st,
                                input logic [4:0] en, input logic bub, input logic rdr,
                                input logic bsy, input int ldr, input int fl);
        vec_t v;
        v.in = in; v.st = st; v.en = en; v.bub = bub; v.rdr = rdr; v.bsy = bsy;
        v.ldr = CW'(ldr); v.fl = CW'(fl);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic drive(input logic [4:0] in);
        {start, halt, stall_for_ldr, branch_taken, clear_stats} = in;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tab[0]  = mk(5'b10000, 3'd1, 5'b10000, 0, 0, 1, 0, 0);
        tab[1]  = mk(5'b00000, 3'd1, 5'b11000, 0, 0, 1, 0, 0);
        tab[2]  = mk(5'b00000, 3'd1, 5'b11100, 0, 0, 1, 0, 0);
        tab[3]  = mk(5'b00000, 3'd1, 5'b11110, 0, 0, 1, 0, 0);
        tab[4]  = mk(5'b00000, 3'd2, 5'b11111, 0, 0, 1, 0, 0);
        tab[5]  = mk(5'b00100, 3'd3, 5'b00111, 1, 0, 1, 1, 0);
        tab[6]  = mk(5'b00100, 3'd2, 5'b11111, 0, 0, 1, 1, 0);
        tab[7]  = mk(5'b00100, 3'd3, 5'b00111, 1, 0, 1, 2, 0);
        tab[8]  = mk(5'b00000, 3'd2, 5'b11111, 0, 0, 1, 2, 0);
        tab[9]  = mk(5'b01110, 3'd4, 5'b00111, 1, 1, 1, 2, 1);
        tab[10] = mk(5'b01000, 3'd4, 5'b10111, 1, 0, 1, 2, 1);
        tab[11] = mk(5'b01000, 3'd2, 5'b11111, 0, 0, 1, 2, 1);
        tab[12] = mk(5'b01000, 3'd5, 5'b01111, 0, 0, 1, 2, 1);
        tab[13] = mk(5'b01000, 3'd5, 5'b00111, 0, 0, 1, 2, 1);
        tab[14] = mk(5'b00110, 3'd5, 5'b00011, 0, 0, 1, 2, 1);
        tab[15] = mk(5'b00000, 3'd5, 5'b00001, 0, 0, 1, 2, 1);
        tab[16] = mk(5'b00000, 3'd6, 5'b00000, 0, 0, 0, 2, 1);
        tab[17] = mk(5'b01000, 3'd6, 5'b00000, 0, 0, 0, 2, 1);
        tab[18] = mk(5'b10000, 3'd1, 5'b10000, 0, 0, 1, 2, 1);
        tab[19] = mk(5'b00010, 3'd1, 5'b11000, 0, 0, 1, 2, 1);
        tab[20] = mk(5'b00100, 3'd1, 5'b11100, 0, 0, 1, 2, 1);
        tab[21] = mk(5'b00010, 3'd4, 5'b00111, 1, 1, 1, 2, 2);
        tab[22] = mk(5'b00000, 3'd4, 5'b10111, 1, 0, 1, 2, 2);
        tab[23] = mk(5'b00000, 3'd2, 5'b11111, 0, 0, 1, 2, 2);
        tab[24] = mk(5'b00001, 3'd2, 5'b11111, 0, 0, 1, 0, 0);
        tab[25] = mk(5'b01100, 3'd5, 5'b01111, 0, 0, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(obs), 32'd0);
        check("reset_cnts", {16'(ldr_stall_count), 16'(flush_count)}, 32'd0);
        reset = 1'b0;
        step();
        check("idle_after_reset", 32'(obs), 32'd0);

        for (int i = 0; i < 26; i++) begin
            drive(tab[i].in);
            step();
            check($sformatf("vec%0d_outs", i), 32'(obs),
                  32'({tab[i].st, tab[i].en, tab[i].bub, tab[i].rdr, tab[i].bsy}));
            check($sformatf("vec%0d_cnts", i), {16'(ldr_stall_count), 16'(flush_count)},
                  {16'(tab[i].ldr), 16'(tab[i].fl)});
        end

        // Saturation of flush_count: restart into RUN, then 255 branches.
        drive(5'b00000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(5'b10000);
        step();
        drive(5'b00000);
        repeat (4) step();
        check("sat_run", 32'(state), 32'd2);
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            drive(5'b00010);
            step();
            drive(5'b00000);
            repeat (2) step();
        end
        check("sat_full", 32'(flush_count), 32'hFF);
        drive(5'b00010);
        step();
        check("sat_hold", 32'(flush_count), 32'hFF);
        check("sat_flush_state", 32'(state), 32'd4);
        drive(5'b00000);
        repeat (2) step();
        check("sat_back_run", 32'(state), 32'd2);
        drive(5'b00011);
        step();
        drive(5'b00000);
        check("clear_beats_inc", 32'(flush_count), 32'd0);
        check("flush_ph0_redirect", 32'(obs), 32'({3'd4, 5'b00111, 1'b1, 1'b1, 1'b1}));

        // Asynchronous reset mid-FLUSH, checked before the next clock edge.
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_outs", 32'(obs), 32'd0);
        check("async_reset_cnts", {16'(ldr_stall_count), 16'(flush_count)}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) step();
        check("stay_idle", 32'(obs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
